// File: rtl/exec_arbiter.sv
// exec_arbiter: shares the single Execute-stage ALU between the main pipeline
// (port 0) and the address/branch helper (port 1). Round-robin arbitration,
// operand registration onto the Execute inputs, fixed LATENCY wait (1..15),
// then a valid/ready response to the granted requester.
// Optional build macro EXEC_ARB_STATS_EN adds saturating 16-bit grant counters
// gnt_cnt0/gnt_cnt1.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; ready goes to the selected requester
// EXEC  | operands held on exe_*, counting down the ALU latency
// RESP  | result held on rsp_data, waiting for the granted rsp ready
module exec_arbiter #(
  parameter int LATENCY = 1,
  parameter int W       = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_imm,
  input  logic [4:0]   req0_shamt,
  input  logic [1:0]   req0_bsel,
  input  logic [3:0]   req0_fun,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_imm,
  input  logic [4:0]   req1_shamt,
  input  logic [1:0]   req1_bsel,
  input  logic [3:0]   req1_fun,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] exe_data_A,
  output logic [W-1:0] exe_data_B,
  output logic [W-1:0] exe_SignExtImm,
  output logic [4:0]   exe_shamt,
  output logic [1:0]   exe_mux_2_flag,
  output logic [3:0]   exe_Alu_function,
  input  logic [W-1:0] exe_ALU,
  output logic         busy
`ifdef EXEC_ARB_STATS_EN
  ,
  output logic [15:0]  gnt_cnt0,
  output logic [15:0]  gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t       state, state_nxt;
  logic         last_grant;
  logic         gnt;
  logic [3:0]   cnt;
  logic         sel;
  logic         any_req;
  logic         accept;
  logic         rsp_ack;
  logic [W-1:0] sel_a, sel_b, sel_imm;
  logic [4:0]   sel_shamt;
  logic [1:0]   sel_bsel;
  logic [3:0]   sel_fun;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_grant;
    else if (req1_valid)          sel = 1'b1;
  end

  assign any_req    = req0_valid | req1_valid;
  assign accept     = (state == IDLE) && any_req;
  assign req0_ready = accept && !sel;
  assign req1_ready = accept && sel;
  assign rsp_ack    = (state == RESP) && (gnt ? rsp1_ready : rsp0_ready);
  assign rsp0_valid = (state == RESP) && !gnt;
  assign rsp1_valid = (state == RESP) && gnt;
  assign busy       = (state != IDLE);

  // Operand mux for the selected requester.
  always_comb begin
    sel_a     = sel ? req1_a     : req0_a;
    sel_b     = sel ? req1_b     : req0_b;
    sel_imm   = sel ? req1_imm   : req0_imm;
    sel_shamt = sel ? req1_shamt : req0_shamt;
    sel_bsel  = sel ? req1_bsel  : req0_bsel;
    sel_fun   = sel ? req1_fun   : req0_fun;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = EXEC;
      EXEC:    if (cnt == 4'd1) state_nxt = RESP;
      RESP:    if (rsp_ack)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, count latency, capture result, update fairness.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_data_A       <= '0;
      exe_data_B       <= '0;
      exe_SignExtImm   <= '0;
      exe_shamt        <= '0;
      exe_mux_2_flag   <= '0;
      exe_Alu_function <= '0;
      rsp_data         <= '0;
      gnt              <= 1'b0;
      cnt              <= '0;
      last_grant       <= 1'b1;
    end else begin
      if (accept) begin
        exe_data_A       <= sel_a;
        exe_data_B       <= sel_b;
        exe_SignExtImm   <= sel_imm;
        exe_shamt        <= sel_shamt;
        // Both 2 and 3 mean "shamt"; Execute only decodes 0..2.
        exe_mux_2_flag   <= (sel_bsel == 2'd3) ? 2'd2 : sel_bsel;
        exe_Alu_function <= sel_fun;
        gnt              <= sel;
        cnt              <= LAT;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) rsp_data <= exe_ALU;
      end
      if (rsp_ack) last_grant <= gnt;
    end
  end

`ifdef EXEC_ARB_STATS_EN
  // Saturating per-requester accept counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && (gnt_cnt0 != 16'hFFFF)) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (req1_ready && (gnt_cnt1 != 16'hFFFF)) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_arbiter.sv
// Directed bench for exec_arbiter: one instance at LATENCY=1, one at LATENCY=3,
// sharing stimulus. A small ALU model stands in for the Execute stage.
module tb_exec_arbiter;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] req0_a, req0_b, req0_imm, req1_a, req1_b, req1_imm;
  logic [4:0]   req0_shamt, req1_shamt;
  logic [1:0]   req0_bsel, req1_bsel;
  logic [3:0]   req0_fun, req1_fun;

  logic         d1_req0_ready, d1_req1_ready, d1_rsp0_valid, d1_rsp1_valid, d1_busy;
  logic [W-1:0] d1_rsp_data, d1_A, d1_B, d1_imm, d1_alu;
  logic [4:0]   d1_shamt;
  logic [1:0]   d1_flag;
  logic [3:0]   d1_fun;

  logic         d3_req0_ready, d3_req1_ready, d3_rsp0_valid, d3_rsp1_valid, d3_busy;
  logic [W-1:0] d3_rsp_data, d3_A, d3_B, d3_imm, d3_alu;
  logic [4:0]   d3_shamt;
  logic [1:0]   d3_flag;
  logic [3:0]   d3_fun;

`ifdef EXEC_ARB_STATS_EN
  logic [15:0] d1_gc0, d1_gc1, d3_gc0, d3_gc1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Execute-stage stand-in: 0 add, 1 sub, 2 shift left, else xor.
  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [W-1:0] imm, input logic [4:0] sh,
                                       input logic [1:0] flag, input logic [3:0] fun);
    logic [W-1:0] op_b;
    op_b = (flag == 2'd0) ? b : (flag == 2'd1) ? imm : {{(W-5){1'b0}}, sh};
    case (fun)
      4'd0:    alu = a + op_b;
      4'd1:    alu = a - op_b;
      4'd2:    alu = a << op_b[4:0];
      default: alu = a ^ op_b;
    endcase
  endfunction

  assign d1_alu = alu(d1_A, d1_B, d1_imm, d1_shamt, d1_flag, d1_fun);
  assign d3_alu = alu(d3_A, d3_B, d3_imm, d3_shamt, d3_flag, d3_fun);

  exec_arbiter #(.LATENCY(1), .W(W)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_shamt(req0_shamt), .req0_bsel(req0_bsel), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_shamt(req1_shamt), .req1_bsel(req1_bsel), .req1_fun(req1_fun),
    .rsp0_valid(d1_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(d1_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(d1_rsp_data), .exe_data_A(d1_A), .exe_data_B(d1_B), .exe_SignExtImm(d1_imm),
    .exe_shamt(d1_shamt), .exe_mux_2_flag(d1_flag), .exe_Alu_function(d1_fun),
    .exe_ALU(d1_alu), .busy(d1_busy)
`ifdef EXEC_ARB_STATS_EN
    , .gnt_cnt0(d1_gc0), .gnt_cnt1(d1_gc1)
`endif
  );

  exec_arbiter #(.LATENCY(3), .W(W)) dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(d3_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_shamt(req0_shamt), .req0_bsel(req0_bsel), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(d3_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_shamt(req1_shamt), .req1_bsel(req1_bsel), .req1_fun(req1_fun),
    .rsp0_valid(d3_rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(d3_rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(d3_rsp_data), .exe_data_A(d3_A), .exe_data_B(d3_B), .exe_SignExtImm(d3_imm),
    .exe_shamt(d3_shamt), .exe_mux_2_flag(d3_flag), .exe_Alu_function(d3_fun),
    .exe_ALU(d3_alu), .busy(d3_busy)
`ifdef EXEC_ARB_STATS_EN
    , .gnt_cnt0(d3_gc0), .gnt_cnt1(d3_gc1)
`endif
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_imm = 0; req0_shamt = 0; req0_bsel = 0; req0_fun = 0;
    req1_a = 0; req1_b = 0; req1_imm = 0; req1_shamt = 0; req1_bsel = 0; req1_fun = 0;
    #3;
    check("rst_busy", d1_busy, 0);
    check("rst_rsp0_valid", d1_rsp0_valid, 0);
    check("rst_exe_A", d1_A, 0);
    check("rst_rsp_data", d1_rsp_data, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single request on port 0, LATENCY=1: 5 + 7.
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_bsel = 0; req0_fun = 0;
    #1;
    check("single_req0_ready", d1_req0_ready, 1);
    check("single_req1_ready", d1_req1_ready, 0);
    tick();
    req0_valid = 0;
    #1;
    check("single_exe_A", d1_A, 5);
    check("single_exe_B", d1_B, 7);
    check("single_flag", d1_flag, 0);
    check("single_busy", d1_busy, 1);
    check("single_no_rsp_yet", d1_rsp0_valid, 0);
    tick();
    check("single_rsp0_valid", d1_rsp0_valid, 1);
    check("single_rsp_data", d1_rsp_data, 12);
    check("single_rsp1_valid", d1_rsp1_valid, 0);
    tick();
    check("single_rsp_held_unacked", d1_rsp0_valid, 1);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    #1;
    check("single_rsp_done", d1_rsp0_valid, 0);
    check("single_data_held", d1_rsp_data, 12);
    check("single_idle", d1_busy, 0);

    // Tie after reset, responders always ready: grants alternate 0,1,0,1.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    req0_valid = 1; req0_a = 10; req0_b = 3; req0_bsel = 0; req0_fun = 1;
    req1_valid = 1; req1_a = 2; req1_imm = 100; req1_bsel = 1; req1_fun = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tie%0d_req0_ready", i), d1_req0_ready, (i % 2 == 0));
      check($sformatf("tie%0d_req1_ready", i), d1_req1_ready, (i % 2 == 1));
      tick();
      if (i == 3) begin
        req0_valid = 0; req1_valid = 0;
      end
      tick();
      check($sformatf("tie%0d_rsp0_valid", i), d1_rsp0_valid, (i % 2 == 0));
      check($sformatf("tie%0d_rsp1_valid", i), d1_rsp1_valid, (i % 2 == 1));
      check($sformatf("tie%0d_rsp_data", i), d1_rsp_data, (i % 2 == 0) ? 7 : 102);
      tick();
    end
`ifdef EXEC_ARB_STATS_EN
    check("stats_gnt_cnt0", d1_gc0, 2);
    check("stats_gnt_cnt1", d1_gc1, 2);
`endif
    check("tie_idle_ready_ignored", d1_rsp0_valid | d1_rsp1_valid, 0);

    // bsel=3 stored as 2, shamt passed through: 1 << 4.
    req1_valid = 1; req1_a = 1; req1_bsel = 3; req1_shamt = 4; req1_fun = 2;
    #1;
    check("shamt_req1_ready", d1_req1_ready, 1);
    tick();
    req1_valid = 0;
    #1;
    check("shamt_flag", d1_flag, 2);
    check("shamt_value", d1_shamt, 4);
    tick();
    check("shamt_rsp1_valid", d1_rsp1_valid, 1);
    check("shamt_rsp_data", d1_rsp_data, 16);
    tick();
    rsp0_ready = 0; rsp1_ready = 0;

    // Backpressure at LATENCY=3 on port 1: 9 + 6.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    req1_valid = 1; req1_a = 9; req1_b = 6; req1_bsel = 0; req1_fun = 0;
    #1;
    check("bp_req1_ready", d3_req1_ready, 1);
    tick();
    req1_valid = 0;
    req0_valid = 1; req0_a = 3; req0_b = 4; req0_bsel = 0; req0_fun = 0;
    #1;
    check("bp_exec_req0_ready", d3_req0_ready, 0);
    tick();
    tick();
    check("bp_exec_no_rsp", d3_rsp1_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rsp1_valid", i), d3_rsp1_valid, 1);
      check($sformatf("bp%0d_rsp_data", i), d3_rsp_data, 15);
      check($sformatf("bp%0d_busy", i), d3_busy, 1);
      check($sformatf("bp%0d_req0_ready", i), d3_req0_ready, 0);
      tick();
    end
    rsp1_ready = 1;
    #1;
    check("bp_ack_cycle_req0_ready", d3_req0_ready, 0);
    tick();
    rsp1_ready = 0;
    #1;
    check("bp_after_req0_ready", d3_req0_ready, 1);
    check("bp_after_rsp1_valid", d3_rsp1_valid, 0);

    // Reset during EXEC discards the transaction.
    tick();
    req0_valid = 0;
    tick();
    check("rstx_busy_before", d3_busy, 1);
    check("rstx_exe_A_before", d3_A, 3);
    reset = 1'b1;
    #1;
    check("rstx_exe_A", d3_A, 0);
    check("rstx_exe_B", d3_B, 0);
    check("rstx_exe_imm", d3_imm, 0);
    check("rstx_exe_shamt", d3_shamt, 0);
    check("rstx_exe_flag", d3_flag, 0);
    check("rstx_exe_fun", d3_fun, 0);
    check("rstx_rsp_data", d3_rsp_data, 0);
    check("rstx_busy", d3_busy, 0);
    check("rstx_rsp_valids", d3_rsp0_valid | d3_rsp1_valid, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rstx%0d_no_rsp", i), d3_rsp0_valid | d3_rsp1_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rstx_tie_req0_ready", d3_req0_ready, 1);
    check("rstx_tie_req1_ready", d3_req1_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: sequence did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_arbiter.md
Name: exec_arbiter

Overview:
- Shares the single Execute-stage ALU between two requesters: the main pipeline on port 0 and the address/branch helper on port 1.
- Arbitrates round-robin and registers the winner's operands, operand-B select and ALU function onto the Execute inputs.
- Waits a configurable ALU latency, then returns the registered result to the granted requester with a valid/ready handshake.

Parameters:
- LATENCY, 1, EXEC cycles before the ALU result is sampled (legal range 1..15).
- W, 32, data width of operands and result.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid, req1_valid  in  1 each  request present.
- req0_ready, req1_ready  out  1 each  request accepted this cycle.
- reqN_a, reqN_b, reqN_imm  in  W each  operand A, register operand B, sign-extended immediate.
- reqN_shamt  in  5  shift amount.
- reqN_bsel  in  2  operand-B select: 0 = reg, 1 = imm, 2 or 3 = shamt.
- reqN_fun  in  4  ALU function code.
- rsp0_valid, rsp1_valid  out  1 each  result valid for that requester.
- rsp0_ready, rsp1_ready  in  1 each  requester takes the result.
- rsp_data  out  W  result, shared by both responders.
- exe_data_A, exe_data_B, exe_SignExtImm  out  W each  to Execute.
- exe_shamt  out  5  to Execute.
- exe_mux_2_flag  out  2  to Execute.
- exe_Alu_function  out  4  to Execute.
- exe_ALU  in  W  Execute result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high.
- Reset values: state = IDLE; all exe_* outputs, rsp_data, rsp0_valid, rsp1_valid and busy are 0; last_grant = 1, so req0 wins the first tie.
- State IDLE:
  - reqN_ready is combinational: high only in IDLE and only for the selected requester.
  - Selection: if exactly one valid, select it; if both valid, select the index != last_grant.
  - On the handshake, register the selected a/b/imm/shamt/fun onto exe_*.
  - exe_mux_2_flag = bsel, except bsel 3 is stored as 2.
  - Set gnt = index, load cnt = LATENCY, go to EXEC.
- State EXEC:
  - cnt decrements each cycle.
  - In the cycle cnt == 1, register exe_ALU into rsp_data and go to RESP.
- State RESP:
  - rsp[gnt]_valid = 1; the other responder's valid = 0.
  - Hold rsp_data stable until rsp[gnt]_ready.
  - On ready, deassert valid, set last_grant = gnt, go to IDLE.
  - No new grant is issued in the same cycle as the response handshake.
- Latency and throughput:
  - Accept-to-rsp_valid latency is LATENCY+1 cycles.
  - Minimum issue interval is LATENCY+2 cycles.
- exe_* outputs hold their last values between transactions.
- rsp_data holds its last value after the response completes.
- Requester changing its inputs while not granted: no effect.
- reqN_valid dropping during EXEC or RESP: no effect; the transaction completes.
- rspN_ready asserted while that rspN_valid is 0: ignored.
- Reset mid-transaction: the transaction is discarded, no response is issued, and all registers return to reset values immediately.
- Widths:
  - exe_shamt is passed through at 5 bits.
  - Zero-extension of shamt to W bits is the Execute stage's job, not this block's.

Optional Feature:
- Macro: EXEC_ARB_STATS_EN.
- When defined, adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each), one per requester.
  - Each increments on its requester's accept handshake.
  - Each saturates at 0xFFFF.
  - Both clear on reset.
- When undefined, these ports and counters do not exist.
- Arbitration and timing are identical either way.

Test Plan:
- Single request, LATENCY=1: req0 a=5, b=7, bsel=0, fun=add.
  - Required: req0_ready the same cycle; exe_data_A=5, exe_data_B=7, exe_mux_2_flag=0 next cycle.
  - Required: rsp0_valid with rsp_data=12 two cycles after accept; rsp1_valid stays 0.
- Tie after reset: req0 and req1 both valid continuously, rsp_ready tied high.
  - Required: grants alternate 0,1,0,1.
  - Required: gnt_cnt0 = gnt_cnt1 = 2 after four transactions (with EXEC_ARB_STATS_EN).
- bsel=3 with shamt=4: required exe_mux_2_flag=2 and exe_shamt=4.
- Backpressure, LATENCY=3: hold rsp1_ready low for 5 cycles.
  - Required: rsp1_valid and rsp_data stable throughout.
  - Required: busy high throughout; req0_ready stays 0 until 1 cycle after rsp1_ready.
- Reset asserted during EXEC:
  - Required: all outputs 0 asynchronously and no rsp_valid afterwards.
  - Required: the next tie is granted to req0.
